// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   SLICE_W : width of the shared adder slice (one nibble)
//   state_e : controller states
//   clog2   : index width helper, never returns less than 1
package nibble_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Bits needed to count 0..n-1, with a floor of one bit so n=1 still has an index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_slice_add.sv
// Combinational 4-bit adder slice shared by the serial sequencer.
//   a_i, b_i : nibble operands
//   ci_i     : carry in
//   s_o      : nibble sum
//   co_o     : carry out
module nibble_slice_add
  import nibble_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, ci_i};

endmodule

// File: rtl/nibble_serial_add_seq.sv
// Multi-cycle controller that reuses one 4-bit slice adder to form a
// 4*NIBBLES-bit sum, least significant nibble first, with a registered carry.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, accepted in IDLE or DONE
//   a, b  : operands, captured on accepted start
//   cin   : carry in to nibble 0, captured on accepted start
//   busy  : high while slices are processed (RUN)
//   done  : one-cycle pulse when sum/cout are valid
//   sum   : result, held from done until the next accepted start
//   cout  : carry out of the top nibble
//   sub   : (only with NIBBLE_SEQ_SUB_EN) 1 selects a - b, cout=1 means no borrow
// Optional feature macro: NIBBLE_SEQ_SUB_EN.
module nibble_serial_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       cout
`ifdef NIBBLE_SEQ_SUB_EN
  ,
  input  logic                       sub
`endif
);

  localparam int unsigned W    = SLICE_W * NIBBLES;
  localparam int unsigned IdxW = clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [W-1:0]       b_cap;
  logic               carry_cap;
  int unsigned        nib_lo;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  // Subtraction is folded in at capture time: b is stored inverted and the
  // initial carry forced to 1, so the RUN datapath is add-only.
`ifdef NIBBLE_SEQ_SUB_EN
  assign b_cap     = sub ? ~b : b;
  assign carry_cap = sub ? 1'b1 : cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  assign nib_lo = 32'(idx_q) * SLICE_W;

  nibble_slice_add u_slice (
    .a_i  (a_q[nib_lo +: SLICE_W]),
    .b_i  (b_q[nib_lo +: SLICE_W]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_cap;
          carry_d = carry_cap;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[nib_lo +: SLICE_W] = slice_s;
        carry_d = slice_co;
        if (idx_q == LastIdx) begin
          cout_d  = slice_co;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq with NIBBLES=4 (16-bit operands).
module tb_nibble_serial_add_seq;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
`ifdef NIBBLE_SEQ_SUB_EN
  logic        sub = 1'b0;
`endif

  nibble_serial_add_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NIBBLE_SEQ_SUB_EN
    ,
    .sub   (sub)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs [9];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; counts cycles until done, bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec);
    int lat, bc;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check({name, "_latency"}, lat, N);
    check({name, "_busy_cycles"}, bc, N);
    check({name, "_sum"}, {16'h0, sum}, {16'h0, es});
    check({name, "_cout"}, {31'h0, cout}, {31'h0, ec});
    @(negedge clk);
    check({name, "_done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int lat, bc;
    logic saw_done;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    vecs[8] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1};

    // Reset state, with start asserted to show reset wins.
    start = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_sum", {16'h0, sum}, 32'h0);
    check("reset_cout", {31'h0, cout}, 32'h0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
    end

    // Result holds in IDLE while inputs move.
    a = 16'h7777; b = 16'h7777;
    repeat (3) @(negedge clk);
    check("idle_hold_sum", {16'h0, sum}, 32'h0);
    check("idle_hold_cout", {31'h0, cout}, 32'h1);

    // Start re-asserted during RUN is ignored, then back-to-back from DONE.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore_latency", lat + 1, N);
    check("ignore_sum", {16'h0, sum}, 32'h5555);
    check("ignore_cout", {31'h0, cout}, 32'h0);
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'h0, busy}, 32'h1);
    check("b2b_done_low", {31'h0, done}, 32'h0);
    wait_done(lat, bc);
    check("b2b_latency", lat, N);
    check("b2b_sum", {16'h0, sum}, 32'h0100);
    check("b2b_cout", {31'h0, cout}, 32'h0);
    @(negedge clk);

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_sum", {16'h0, sum}, 32'h0);
    check("abort_cout", {31'h0, cout}, 32'h0);
    saw_done = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_stays_idle", {31'h0, saw_done}, 32'h0);
    run_op("after_abort", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

`ifdef NIBBLE_SEQ_SUB_EN
    sub = 1'b1;
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
